uart_rx_frame: RTL and testbench

//   Standalone UART receiver: recovers 8N1/8E1/8O1 frames from an asynchronous serial line.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx_frame.sv | 145 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and a counter-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam bit PARITY_MODE_EVEN = 1'b0;
    localparam bit PARITY_MODE_ODD  = 1'b1;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module uart_sync2 #(
    parameter bit RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: oversampled start/data/parity/stop recovery with error flags and a done strobe.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATABITS   = 8,
    parameter int unsigned BAUD_DIV   = 2604,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = PARITY_MODE_EVEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_line,
    output logic [DATABITS-1:0] rx_data,
    output logic                rx_done,
    output logic                parity_error,
    output logic                framing_error,
    output logic                busy
);

    localparam int unsigned CW = cnt_width(BAUD_DIV);
    localparam int unsigned IW = cnt_width(DATABITS);
    localparam logic [CW-1:0] BCNT_HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] BCNT_LAST = CW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATABITS - 1);

    uart_state_t         state;
    logic                rx_s;
    logic                rx_d;
    logic                fall_c;
    logic [CW-1:0]       bcnt;
    logic [IW-1:0]       idx;
    logic [DATABITS-1:0] shreg;
    logic                perr;
    logic                ferr;
    logic                fin;
    logic                armed;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_line),
        .q     (rx_s)
    );

    assign fall_c = rx_d & ~rx_s;

    // Frame FSM and datapath; fin marks the cycle between the stop sample and the strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            rx_d          <= 1'b1;
            bcnt          <= '0;
            idx           <= '0;
            shreg         <= '0;
            perr          <= 1'b0;
            ferr          <= 1'b0;
            fin           <= 1'b0;
            armed         <= 1'b1;
            rx_data       <= '0;
            rx_done       <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_d    <= rx_s;
            rx_done <= 1'b0;
            if (rx_s) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (armed && fall_c) begin
                        state <= ST_START;
                        bcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bcnt == BCNT_HALF) begin
                        bcnt <= '0;
                        perr <= 1'b0;
                        if (rx_s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                            idx   <= '0;
                        end
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bcnt == BCNT_LAST) begin
                        bcnt       <= '0;
                        shreg[idx] <= rx_s;
                        if (idx == IDX_LAST) begin
                            state <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (bcnt == BCNT_LAST) begin
                        bcnt  <= '0;
                        perr  <= (^shreg) ^ rx_s ^ PARITY_ODD;
                        state <= ST_STOP;
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (fin) begin
                        fin           <= 1'b0;
                        bcnt          <= '0;
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                        rx_data       <= shreg;
                        parity_error  <= PARITY_EN & perr;
                        framing_error <= ferr;
                        rx_done       <= 1'b1;
                        // A break keeps the line low; require it high before the next start.
                        if (ferr && !rx_s) begin
                            armed <= 1'b0;
                        end
                    end else if (bcnt == BCNT_LAST) begin
                        ferr <= ~rx_s;
                        fin  <= 1'b1;
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: even-parity, odd-parity and no-parity instances.
module tb_uart_rx_frame;

    localparam int BD = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] line = 3'b111;
    logic [7:0] rx_data [3];
    logic [2:0] rx_done;
    logic [2:0] parity_error;
    logic [2:0] framing_error;
    logic [2:0] busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   done_cnt [3];
    int   last_done [3];
    exp_t sb [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // 0: even parity, 1: odd parity, 2: no parity
    for (genvar g = 0; g < 3; g++) begin : g_dut
        exp_t e;

        uart_rx_frame #(
            .DATABITS   (8),
            .BAUD_DIV   (BD),
            .PARITY_EN  (g != 2),
            .PARITY_ODD (g == 1)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .rx_line       (line[g]),
            .rx_data       (rx_data[g]),
            .rx_done       (rx_done[g]),
            .parity_error  (parity_error[g]),
            .framing_error (framing_error[g]),
            .busy          (busy[g])
        );

        initial begin
            done_cnt[g]  = 0;
            last_done[g] = 0;
        end

        always @(negedge clk) begin
            if (rx_done[g] === 1'b1) begin
                done_cnt[g]++;
                last_done[g] = cyc;
                n_tests++;
                if (sb[g].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe dut%0d: rx_data=%02h, no frame expected", g, rx_data[g]);
                end else begin
                    e = sb[g].pop_front();
                    n_tests += 2;
                    if (rx_data[g] !== e.data) begin
                        n_fail++;
                        $display("FAIL rx_data dut%0d: got %02h want %02h", g, rx_data[g], e.data);
                    end
                    if (parity_error[g] !== e.perr) begin
                        n_fail++;
                        $display("FAIL parity_error dut%0d: got %b want %b (data %02h)", g, parity_error[g], e.perr, e.data);
                    end
                    if (framing_error[g] !== e.ferr) begin
                        n_fail++;
                        $display("FAIL framing_error dut%0d: got %b want %b (data %02h)", g, framing_error[g], e.ferr, e.data);
                    end
                end
            end
        end
    end

    task automatic drive_bit(input int sel, input logic b);
        line[sel] = b;
        repeat (BD) @(posedge clk);
        #1;
    endtask

    task automatic send(input int sel, input logic [7:0] d, input bit par_en, input bit par_odd,
                        input bit flip, input bit stop);
        exp_t e;
        e.data = d;
        e.perr = par_en & flip;
        e.ferr = ~stop;
        sb[sel].push_back(e);
        drive_bit(sel, 1'b0);
        n_tests++;
        if (busy[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_frame dut%0d: got %b want 1", sel, busy[sel]);
        end
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_en) drive_bit(sel, (^d) ^ par_odd ^ flip);
        drive_bit(sel, stop);
    endtask

    task automatic wait_drain(input int sel);
        int k = 0;
        while (sb[sel].size() != 0 && k < 64) begin
            @(posedge clk);
            k++;
        end
        #1;
        n_tests++;
        if (sb[sel].size() != 0) begin
            n_fail++;
            $display("FAIL missing_strobe dut%0d: %0d frames pending want 0", sel, sb[sel].size());
            sb[sel].delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests += 4;
        if (rx_data[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rx_data: got %02h want 00", rx_data[0]);
        end
        if (rx_done !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_rx_done: got %b want 000", rx_done);
        end
        if ((parity_error | framing_error) !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b/%b want 000/000", parity_error, framing_error);
        end
        if (busy !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 000", busy);
        end
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_good_frame();
        send(0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain(0);
        repeat (20) @(posedge clk);
        #1;
        n_tests += 2;
        if (rx_data[0] !== 8'h55) begin
            n_fail++;
            $display("FAIL rx_data_held: got %02h want 55", rx_data[0]);
        end
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_frame: got %b want 0", busy[0]);
        end
    endtask

    task automatic test_parity_error();
        send(0, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_drain(0);
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (parity_error[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_error_held: got %b want 1", parity_error[0]);
        end
        send(0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain(0);
    endtask

    task automatic test_break();
        int d0 = done_cnt[0];
        send(0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5 * BD) @(posedge clk);
        #1;
        line[0] = 1'b1;
        repeat (3 * BD) @(posedge clk);
        wait_drain(0);
        n_tests += 2;
        if (done_cnt[0] - d0 !== 1) begin
            n_fail++;
            $display("FAIL break_strobes: got %0d want 1", done_cnt[0] - d0);
        end
        if (framing_error[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL break_framing_held: got %b want 1", framing_error[0]);
        end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt[0];
        bit seen_busy = 1'b0;
        int k = 0;
        line[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        line[0] = 1'b1;
        @(negedge clk);
        seen_busy = busy[0];
        while (busy[0] !== 1'b0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_tests += 3;
        if (seen_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_rise: got %b want 1", seen_busy);
        end
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy_fall: got %b want 0 after %0d cycles", busy[0], k);
        end
        repeat (12 * BD) @(posedge clk);
        #1;
        if (done_cnt[0] !== d0) begin
            n_fail++;
            $display("FAIL glitch_strobe: got %0d strobes want 0", done_cnt[0] - d0);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        send(0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1);
        t1 = last_done[0];
        send(0, 8'h34, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain(0);
        t2 = last_done[0];
        n_tests++;
        if (t2 - t1 !== 11 * BD) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", t2 - t1, 11 * BD);
        end
    endtask

    task automatic test_reset_mid();
        line[0] = 1'b0;
        repeat (BD) @(posedge clk);
        #1;
        line[0] = 1'b1;
        repeat (3 * BD) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_tests += 3;
        if (rx_data[0] !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_rx_data: got %02h want 00", rx_data[0]);
        end
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_busy: got %b want 0", busy[0]);
        end
        if ({rx_done[0], parity_error[0], framing_error[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_flags: got %b want 000",
                     {rx_done[0], parity_error[0], framing_error[0]});
        end
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2 * BD) @(posedge clk);
        #1;
        send(0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_drain(0);
    endtask

    task automatic test_param_variants();
        send(1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_drain(1);
        send(1, 8'hC4, 1'b1, 1'b1, 1'b1, 1'b1);
        wait_drain(1);
        send(2, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain(2);
        send(2, 8'h9E, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_drain(2);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_break();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        test_param_variants();
        repeat (4 * BD) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
